// File: rtl/mux4_scan_ctrl_if.sv
// rtl/mux4_scan_ctrl_if.sv - scan controller handshake bundle (par present with MUX4_SCAN_PARITY_EN)
interface mux4_scan_ctrl_if;
  logic       start;
  logic       y;
  logic [1:0] s;
  logic [3:0] q;
  logic       valid;
  logic       ready;
  logic       busy;
`ifdef MUX4_SCAN_PARITY_EN
  logic       par;
`endif

`ifdef MUX4_SCAN_PARITY_EN
  modport master (input start, input y, input ready,
                  output s, output q, output valid, output busy, output par);
  modport slave  (output start, output y, output ready,
                  input s, input q, input valid, input busy, input par);
`else
  modport master (input start, input y, input ready,
                  output s, output q, output valid, output busy);
  modport slave  (output start, output y, output ready,
                  input s, input q, input valid, input busy);
`endif
endinterface

// File: rtl/mux4_scan_ctrl.sv
// rtl/mux4_scan_ctrl.sv - steps a 4:1 mux select and assembles its output into a word; MUX4_SCAN_PARITY_EN adds par
module mux4_scan_ctrl #(
  parameter int SETTLE = 0,
  parameter int CW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mux4_scan_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  state_t        state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    buf_q, buf_d;
  logic [3:0]    q_q, q_d;
  logic          valid_q, valid_d;
`ifdef MUX4_SCAN_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      cnt_q   <= '0;
      buf_q   <= 3'd0;
      q_q     <= 4'd0;
      valid_q <= 1'b0;
`ifdef MUX4_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      q_q     <= q_d;
      valid_q <= valid_d;
`ifdef MUX4_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    q_d     = q_q;
    valid_d = valid_q;
`ifdef MUX4_SCAN_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        s_d     = 2'd0;
        valid_d = 1'b0;
        if (bus.start) begin
          state_d = SCAN;
          cnt_d   = '0;
          buf_d   = 3'd0;
        end
      end
      SCAN: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Last edge of the slot: y has had SETTLE+1 cycles to settle
          cnt_d = '0;
          unique case (s_q)
            2'd0: buf_d[0] = bus.y;
            2'd1: buf_d[1] = bus.y;
            2'd2: buf_d[2] = bus.y;
            default: ;
          endcase
          if (s_q != 2'd3) begin
            s_d = s_q + 2'd1;
          end else begin
            s_d     = 2'd0;
            q_d     = {bus.y, buf_q};
            valid_d = 1'b1;
            state_d = DONE;
`ifdef MUX4_SCAN_PARITY_EN
            par_d   = ^{bus.y, buf_q};
`endif
          end
        end
      end
      DONE: begin
        s_d = 2'd0;
        if (valid_q && bus.ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s     = s_q;
  assign bus.q     = q_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);
`ifdef MUX4_SCAN_PARITY_EN
  assign bus.par   = par_q;
`endif

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Sequencer that drives the select input `s` of the 4:1 mux (mux4_inst) and consumes its output `y`.
- Steps `s` through 0..3 and samples `y` once per select value, giving a 4-bit word `q`, where `q[i]` is the value seen on `d[i]`.
- Delivers `q` downstream with a valid/ready handshake.
- Used to read back a mux-selected data bus one bit per select slot.

Parameters:
- SETTLE, 0, extra cycles each select value is held before `y` is sampled (0..15); each slot lasts SETTLE+1 cycles.
- CW, 4, width of the internal settle counter; the design must satisfy SETTLE < 2**CW.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  scan request; sampled only in IDLE
- y  input  1  mux output being scanned
- s  output  2  select driven to mux; registered
- q  output  4  assembled word; q[i] = y captured while s==i
- valid  output  1  q holds a completed scan
- ready  input  1  downstream accepts q
- busy  output  1  high in SCAN or DONE

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high, sampled on the `clk` rising edge, and overrides everything.
- Reset values: state=IDLE, s=0, cnt=0, q=0, valid=0, busy=0. Internal capture buffer buf=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - s=0, valid=0.
  - At an edge with start=1: go to SCAN, with s=0, cnt=0, buf=0.
- SCAN, at each edge:
  - If cnt<SETTLE: cnt<=cnt+1.
  - If cnt==SETTLE: buf[s]<=y and cnt<=0.
    - If s<3: s<=s+1.
    - If s==3: q<={y,buf[2:0]}, valid<=1, state<=DONE, s<=0.
- Latency: start accepted at edge E0 gives valid=1 after edge E0+4*(SETTLE+1). With SETTLE=0 this is 4 cycles.
- Sample point: `y` is sampled at the final edge of each slot. The combinational mux path therefore has SETTLE+1 cycles to settle.
- DONE:
  - q and valid are held stable; s=0.
  - At an edge with valid&&ready: valid<=0, state<=IDLE. q keeps its last value.
- start is ignored in SCAN and DONE; it is not queued.
- start=1 and ready=1 in the same DONE cycle: return to IDLE only. A new scan needs start high in IDLE on a later edge.
- ready held high continuously: each result is valid for exactly 1 cycle.
- ready asserted while valid=0: no effect.
- rst mid-SCAN or mid-DONE: the partial word is discarded and all reset values apply on the next edge.
- busy is combinational: (state!=IDLE).
- Values of `y` outside a sample edge are don't-care. X on `y` propagates only into the corresponding bit of `q`.

Optional Feature:
- Macro: MUX4_SCAN_PARITY_EN.
- Defined:
  - Adds output port `par` (1 bit) = ^q, registered together with q.
  - `par` resets to 0 and is held in DONE like q.
- Undefined:
  - Port `par` does not exist.
  - No parity logic is built.
  - All other behaviour is identical.

Test Plan:
- SETTLE=0, mux d=4'b1010, start pulse 1 cycle, ready=1 -> s goes 0,1,2,3 on consecutive cycles; valid=1 for exactly 1 cycle, 4 cycles after the start edge; q=4'b1010.
- SETTLE=2, d=4'b0110, ready=0 -> each s value is held 3 cycles; valid rises 12 cycles after start; q=4'b0110 and valid remain stable for 10 cycles, then clear 1 cycle after ready=1.
- SETTLE=0, d changed from 4'b1111 to 4'b0000 after s has passed 1 -> q=4'b0011, proving per-slot sampling.
- start held high through SCAN and DONE with ready=1 -> no second scan starts until after IDLE is reached; the next scan starts 1 cycle later; busy low for exactly 1 cycle between scans.
- rst=1 for 1 cycle while s==2 in SCAN -> next cycle s=0, valid=0, q=0, busy=0; a fresh start then produces a correct word.
- With MUX4_SCAN_PARITY_EN: d=4'b0111 -> par=1; d=4'b0101 -> par=0. Without the macro: the bench compiles and the same scans pass.
